// File: rtl/rom_fetch_sequencer_if.sv
// rom_fetch_sequencer_if
//   Bundles the two buses of the ROM fetch sequencer:
//     ROM side    : rom_addr, rom_en (to ROM), rom_data (from ROM)
//     stream side : data_out, data_valid (to consumer), data_ready (from consumer)
//   master = sequencer view, slave = ROM + downstream consumer view.
interface rom_fetch_sequencer_if #(
    parameter int ROM_WIDTH     = 8,
    parameter int ROM_ADDR_BITS = 8
);
    logic [ROM_ADDR_BITS-1:0] rom_addr;
    logic                     rom_en;
    logic [ROM_WIDTH-1:0]     rom_data;
    logic [ROM_WIDTH-1:0]     data_out;
    logic                     data_valid;
    logic                     data_ready;

    modport master (
        output rom_addr, rom_en, data_out, data_valid,
        input  rom_data, data_ready
    );

    modport slave (
        input  rom_addr, rom_en, data_out, data_valid,
        output rom_data, data_ready
    );
endinterface

// File: rtl/rom_fetch_sequencer.sv
// rom_fetch_sequencer
//   Reads a synchronous (1-cycle registered) lookup ROM at a prescaled rate,
//   stepping the address up or down with wrap-around, and presents each word
//   on a VALID/READY stream.
// Ports
//   clk          system clock, posedge
//   rst_n        asynchronous active-low reset
//   run_i        prescaler counts when 1, holds when 0
//   dir_i        1 = step up, 0 = step down (used only on handshake)
//   load_i       load load_addr_i, abort any fetch in flight
//   load_addr_i  address to load
//   bus          master side of rom_fetch_sequencer_if (ROM + output stream)
module rom_fetch_sequencer #(
    parameter int ROM_WIDTH     = 8,
    parameter int ROM_ADDR_BITS = 8,
    parameter int TICK_DIV      = 100000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run_i,
    input  logic                     dir_i,
    input  logic                     load_i,
    input  logic [ROM_ADDR_BITS-1:0] load_addr_i,
    rom_fetch_sequencer_if.master    bus
);
    localparam int CNT_W = $clog2(TICK_DIV + 1);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, PRESENT} state_e;

    state_e                   state_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     pend_q, pend_d;
    logic [ROM_ADDR_BITS-1:0] addr_q;
    logic [ROM_WIDTH-1:0]     dout_q;
    logic                     valid_q;
    logic                     tick;
    logic                     hs;

    assign tick = run_i && (cnt_q == CNT_W'(TICK_DIV - 1));
    assign hs   = valid_q && bus.data_ready;

    // Prescaler: free-running while run_i, frozen otherwise; LOAD leaves it alone.
    always_comb begin
        cnt_d = cnt_q;
        if (run_i) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Single pending slot: consumed when IDLE starts a fetch (a tick in that
    // same cycle is dropped), otherwise any tick sets it. LOAD re-arms it.
    always_comb begin
        pend_d = pend_q;
        if (load_i)                          pend_d = 1'b1;
        else if (state_q == IDLE && pend_q)  pend_d = 1'b0;
        else if (tick)                       pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pend_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            // LOAD beats a same-cycle handshake; dout_q deliberately kept.
            state_q <= IDLE;
            addr_q  <= load_addr_i;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (pend_q) state_q <= FETCH;
                FETCH:   state_q <= CAPTURE;
                CAPTURE: begin
                    dout_q  <= bus.rom_data;
                    valid_q <= 1'b1;
                    state_q <= PRESENT;
                end
                PRESENT: if (hs) begin
                    valid_q <= 1'b0;
                    addr_q  <= dir_i ? addr_q + ROM_ADDR_BITS'(1)
                                     : addr_q - ROM_ADDR_BITS'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rom_addr   = addr_q;
    assign bus.rom_en     = (state_q == FETCH);
    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// tb_rom_fetch_sequencer
//   Drives rom_fetch_sequencer against a ROM model (mem[a] = a ^ 8'hA5) and a
//   cycle-level behavioural model; directed scenarios plus a random phase.
module tb_rom_fetch_sequencer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0, dir = 1'b1, load = 1'b0, ready = 1'b1;
    logic [7:0] load_addr = 8'h00;
    logic [7:0] rom_q;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic [7:0] acc_q[$];
    int         en_q[$];

    rom_fetch_sequencer_if #(.ROM_WIDTH(8), .ROM_ADDR_BITS(8)) bus ();

    rom_fetch_sequencer #(.ROM_WIDTH(8), .ROM_ADDR_BITS(8), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run),
        .dir_i      (dir),
        .load_i     (load),
        .load_addr_i(load_addr),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // ROM: 1-cycle registered read
    always @(posedge clk) if (bus.rom_en) rom_q <= bus.rom_addr ^ 8'hA5;
    assign bus.rom_data   = rom_q;
    assign bus.data_ready = ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_ph: -1 = no fetch in progress, 0 = ROM enabled this cycle, 1 = ROM word arriving
    int         m_cnt;
    bit         m_pend;
    int         m_ph;
    bit         m_valid;
    logic [7:0] m_dout, m_addr;
    wire        m_tick = run && (m_cnt == TD - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_pend <= 1'b1; m_ph <= -1;
            m_valid <= 1'b0; m_dout <= 8'h00; m_addr <= 8'h00;
        end else begin
            if (run) m_cnt <= (m_cnt + 1) % TD;
            if (load) begin
                m_addr <= load_addr; m_valid <= 1'b0; m_ph <= -1; m_pend <= 1'b1;
            end else begin
                if (m_ph == -1 && !m_valid && m_pend) begin
                    m_ph <= 0; m_pend <= 1'b0;
                end else if (m_tick) m_pend <= 1'b1;
                if (m_ph == 0) m_ph <= 1;
                if (m_ph == 1) begin
                    m_ph <= -1; m_valid <= 1'b1; m_dout <= m_addr ^ 8'hA5;
                end
                if (m_valid && ready) begin
                    m_valid <= 1'b0;
                    m_addr  <= dir ? m_addr + 8'd1 : m_addr - 8'd1;
                end
            end
        end
    end

    // compare every cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            chk("rom_en",     {31'd0, bus.rom_en},     {31'd0, m_ph == 0});
            chk("rom_addr",   {24'd0, bus.rom_addr},   {24'd0, m_addr});
            chk("data_valid", {31'd0, bus.data_valid}, {31'd0, m_valid});
            chk("data_out",   {24'd0, bus.data_out},   {24'd0, m_dout});
            if (bus.rom_en) en_q.push_back(cyc);
        end
    end

    // accepted words (LOAD in the same cycle cancels acceptance)
    always @(posedge clk)
        if (rst_n && bus.data_valid && ready && !load) acc_q.push_back(bus.data_out);

    // scenario 1 behaviour: called at a negedge with rst_n low
    task automatic reset_fetch(input string tag);
        int n_en;
        n_en = 0;
        run = 0; ready = 1; dir = 1; load = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rom_en) n_en++;
            if (i == 2) begin
                chk({tag, "_valid_e3"}, {31'd0, bus.data_valid}, 32'd1);
                chk({tag, "_data_e3"},  {24'd0, bus.data_out},   32'hA5);
            end
        end
        chk({tag, "_addr_after"}, {24'd0, bus.rom_addr}, 32'h01);
        chk({tag, "_en_pulses"},  n_en, 1);
    endtask

    initial begin : stim
        logic [7:0] hold_d, hold_a;
        int bad, n_en;

        repeat (3) @(negedge clk);
        chk("reset_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("reset_en",    {31'd0, bus.rom_en},     32'd0);
        chk("reset_addr",  {24'd0, bus.rom_addr},   32'd0);

        // 1: single fetch after reset
        reset_fetch("s1");

        // 2: counting up from 0
        run = 1; dir = 1; ready = 1; load_addr = 8'h00; load = 1;
        @(negedge clk); load = 0;
        acc_q.delete(); en_q.delete();
        for (int i = 0; i < 200 && acc_q.size() < 5; i++) @(negedge clk);
        chk("s2_count", acc_q.size() >= 5, 1);
        if (acc_q.size() >= 5 && en_q.size() >= 5) begin
            chk("s2_w0", acc_q[0], 32'hA5);
            chk("s2_w1", acc_q[1], 32'hA4);
            chk("s2_w2", acc_q[2], 32'hA7);
            chk("s2_w3", acc_q[3], 32'hA6);
            for (int k = 1; k < 4; k++) chk("s2_en_gap", en_q[k+1] - en_q[k], 4);
        end

        // 3: wrap up from FF, then wrap down from 00
        dir = 1; load_addr = 8'hFF; load = 1;
        @(negedge clk); load = 0; acc_q.delete();
        for (int i = 0; i < 100 && acc_q.size() < 2; i++) @(negedge clk);
        chk("s3_up_count", acc_q.size() >= 2, 1);
        if (acc_q.size() >= 2) begin
            chk("s3_up_w0", acc_q[0], 32'h5A);
            chk("s3_up_w1", acc_q[1], 32'hA5);
        end
        dir = 0; load_addr = 8'h00; load = 1;
        @(negedge clk); load = 0; acc_q.delete();
        for (int i = 0; i < 100 && acc_q.size() < 2; i++) @(negedge clk);
        chk("s3_dn_count", acc_q.size() >= 2, 1);
        if (acc_q.size() >= 2) begin
            chk("s3_dn_w0", acc_q[0], 32'hA5);
            chk("s3_dn_w1", acc_q[1], 32'h5A);
        end

        // 4: backpressure
        run = 1; dir = 1; ready = 0;
        for (int i = 0; i < 50 && !bus.data_valid; i++) @(negedge clk);
        chk("s4_valid_seen", {31'd0, bus.data_valid}, 32'd1);
        hold_d = bus.data_out; hold_a = bus.rom_addr; bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.data_out !== hold_d || bus.rom_addr !== hold_a ||
                bus.rom_en !== 1'b0 || bus.data_valid !== 1'b1) bad++;
        end
        chk("s4_stable", bad, 0);
        run = 0; ready = 1; n_en = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.rom_en) n_en++;
        end
        chk("s4_one_extra", n_en, 1);

        // 5: LOAD during FETCH, then during CAPTURE
        run = 0; ready = 1; dir = 1; load_addr = 8'h33; load = 1;
        @(negedge clk); load = 0; acc_q.delete();
        for (int i = 0; i < 20 && !bus.rom_en; i++) @(negedge clk);
        chk("s5_fetch1", {31'd0, bus.rom_en}, 32'd1);
        load_addr = 8'h10; load = 1;
        @(negedge clk); load = 0;
        for (int i = 0; i < 20 && !bus.rom_en; i++) @(negedge clk);
        chk("s5_fetch10", {24'd0, bus.rom_addr}, 32'h10);
        @(negedge clk);
        load_addr = 8'h20; load = 1;
        @(negedge clk); load = 0;
        for (int i = 0; i < 50 && acc_q.size() < 1; i++) @(negedge clk);
        chk("s5_count", acc_q.size() >= 1, 1);
        if (acc_q.size() >= 1) chk("s5_word", acc_q[0], 32'h85);

        // random phase
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            run       = ($urandom_range(0, 3) != 0);
            dir       = $urandom_range(0, 1);
            ready     = ($urandom_range(0, 9) < 7);
            load      = ($urandom_range(0, 24) == 0);
            load_addr = 8'($urandom_range(0, 255));
        end
        @(negedge clk); load = 0; ready = 1;

        // 6: async reset during PRESENT
        run = 0; ready = 0; load_addr = 8'h42; load = 1;
        @(negedge clk); load = 0;
        for (int i = 0; i < 20 && !bus.data_valid; i++) @(negedge clk);
        chk("s6_valid_seen", {31'd0, bus.data_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("s6_rst_data",  {24'd0, bus.data_out},   32'd0);
        chk("s6_rst_addr",  {24'd0, bus.rom_addr},   32'd0);
        chk("s6_rst_en",    {31'd0, bus.rom_en},     32'd0);
        @(negedge clk);
        reset_fetch("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
